// File: rtl/mem_responder.sv
// Single-outstanding memory responder: a request is latched, held for a
// programmable number of wait cycles, then serviced from an internal word RAM.
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_reg;
  logic [3:0]    cnt_reg;
  logic          we_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic          err_reg;
  logic          rd_ok_reg;
  logic [31:0]   ram_q;
  logic [31:0]   ram [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  assign accept = req_valid && (state_reg == S_IDLE);

  // With zero latency the access happens on the accepting edge itself, so the
  // live request fields are used; otherwise the latched copy is used.
  always_comb begin
    acc_we    = we_reg;
    acc_addr  = addr_reg;
    acc_wdata = wdata_reg;
    if (state_reg == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign enter_resp = (LATENCY == 0) ? accept
                                     : ((state_reg == S_WAIT) && (cnt_reg == 4'd0));
  assign acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
  assign acc_idx    = acc_addr[AW+1:2];

  // RAM contents are never reset; reset only gates the access so an aborted
  // write cannot land.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && !acc_err) begin
      if (acc_we) begin
        ram[acc_idx] <= acc_wdata;
      end else begin
        ram_q <= ram[acc_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      err_reg   <= 1'b0;
      rd_ok_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            if (LATENCY == 0) begin
              state_reg <= S_RESP;
            end else begin
              state_reg <= S_WAIT;
              cnt_reg   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_reg <= S_IDLE;
            err_reg   <= 1'b0;
            rd_ok_reg <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
      if (enter_resp) begin
        err_reg   <= acc_err;
        rd_ok_reg <= !acc_we && !acc_err;
      end
    end
  end

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_err   = err_reg;
  assign rsp_rdata = rd_ok_reg ? ram_q : 32'd0;

endmodule
